// File: rtl/withdraw.sv
// withdraw: ATM withdrawal controller.
// Checks a requested note count against the balance and the per-transaction
// limit, then dispenses notes one at a time over a req/ack handshake and
// pulses count_down once per dispensed note.
// Optional feature macro: WD_DAILY_LIMIT_EN adds a cumulative daily note limit
// that is cleared by day_clr.
module withdraw #(
    parameter int AMT_W       = 8,
    parameter int BAL_W       = 16,
    parameter int MAX_NOTES   = 40,
    parameter int TIMEOUT     = 1000,
    parameter int DAILY_LIMIT = 100
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wd_en,
    input  logic [AMT_W-1:0] amount,
    input  logic [BAL_W-1:0] balance,
    input  logic             disp_ack,
    input  logic             day_clr,
    output logic             disp_req,
    output logic             count_down,
    output logic             busy,
    output logic             done,
    output logic             deny,
    output logic             fault
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CMP_W = ((AMT_W > BAL_W) ? AMT_W : BAL_W) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [CMP_W-1:0] MAX_EXT   = CMP_W'(MAX_NOTES);
    localparam logic [AMT_W-1:0] REM_ONE   = AMT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DISP,
        S_NEXT,
        S_DONE,
        S_DENY,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             prev_q, prev_d;

    logic             start_req;
    logic             deny_cond;
    logic             daily_deny;

    logic [CMP_W-1:0] rem_ext;
    logic [CMP_W-1:0] bal_ext;

    assign rem_ext   = CMP_W'(rem_q);
    assign bal_ext   = CMP_W'(balance);
    assign start_req = wd_en & ~prev_q;
    assign prev_d    = wd_en;

`ifdef WD_DAILY_LIMIT_EN
    localparam int DAY_W = 16;
    localparam int SUM_W = ((DAY_W > AMT_W) ? DAY_W : AMT_W) + 1;
    localparam logic [SUM_W-1:0] DAY_LIM = SUM_W'(DAILY_LIMIT);

    logic [DAY_W-1:0] daily_total_q, daily_total_d;
    logic [SUM_W-1:0] daily_sum;

    assign daily_sum  = SUM_W'(daily_total_q) + SUM_W'(rem_q);
    assign daily_deny = (daily_sum > DAY_LIM);

    // Daily total counts dispensed notes, saturates, and day_clr overrides an increment
    always_comb begin
        daily_total_d = daily_total_q;
        if (day_clr) begin
            daily_total_d = '0;
        end else if ((state_q == S_NEXT) && (daily_total_q != {DAY_W{1'b1}})) begin
            daily_total_d = daily_total_q + DAY_W'(1);
        end
    end

    // Daily total register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            daily_total_q <= '0;
        end else begin
            daily_total_q <= daily_total_d;
        end
    end
`else
    localparam logic [31:0] DAILY_LIMIT_U = DAILY_LIMIT;
    logic unused_daily;

    assign unused_daily = ^{day_clr, DAILY_LIMIT_U};
    assign daily_deny   = 1'b0;
`endif

    assign deny_cond = (rem_q == '0) || (rem_ext > bal_ext) || (rem_ext > MAX_EXT) || daily_deny;

    // State and datapath registers; prev resets high so a held wd_en is not an edge
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            timer_q <= '0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            prev_q  <= prev_d;
        end
    end

    // Next-state logic and per-state updates of remaining notes and ack timer
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    rem_d   = amount;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (deny_cond) begin
                    state_d = S_DENY;
                end else begin
                    timer_d = '0;
                    state_d = S_DISP;
                end
            end
            S_DISP: begin
                if (disp_ack) begin
                    state_d = S_NEXT;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_NEXT: begin
                rem_d   = rem_q - REM_ONE;
                timer_d = '0;
                state_d = (rem_q == REM_ONE) ? S_DONE : S_DISP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DENY: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                rem_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from the registered state
    always_comb begin
        disp_req   = 1'b0;
        count_down = 1'b0;
        done       = 1'b0;
        deny       = 1'b0;
        fault      = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_DISP:  disp_req   = 1'b1;
            S_NEXT:  count_down = 1'b1;
            S_DONE:  done       = 1'b1;
            S_DENY:  deny       = 1'b1;
            S_FAULT: fault      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_withdraw.sv
// tb_withdraw: directed self-checking bench for the withdraw controller.
// Each transaction is counted from cycle 0, the cycle in which the wd_en
// rising edge is first sampled.
module tb_withdraw;

    logic       clk;
    logic       res;
    logic       wd_en;
    logic [7:0] amount;
    logic [15:0] balance;
    logic       disp_ack;
    logic       day_clr;
    logic       disp_req;
    logic       count_down;
    logic       busy;
    logic       done;
    logic       deny;
    logic       fault;

    int checks;
    int failures;

    int cyc;
    int nDown;
    int nDone;
    int nDeny;
    int nFault;
    int nReqRise;
    int nReqCycles;
    int doneCyc;
    int denyCyc;
    int faultCyc;
    int lastRiseCyc;
    int timedOut;
    int sawBusy;

    withdraw #(
        .AMT_W      (8),
        .BAL_W      (16),
        .MAX_NOTES  (40),
        .TIMEOUT    (1000),
        .DAILY_LIMIT(5)
    ) dut (
        .clk       (clk),
        .res       (res),
        .wd_en     (wd_en),
        .amount    (amount),
        .balance   (balance),
        .disp_ack  (disp_ack),
        .day_clr   (day_clr),
        .disp_req  (disp_req),
        .count_down(count_down),
        .busy      (busy),
        .done      (done),
        .deny      (deny),
        .fault     (fault)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Runs one transaction with a dispenser that acks in the second cycle of each
    // request, acking at most ackNotes notes; strayMode adds stray acks and extra
    // wd_en edges while the controller is busy.
    task automatic applyStimulus(input int amt, input int bal, input int ackNotes,
                                 input int strayMode, input int maxCycles);
        int ackGiven;
        logic prevReq;
        ackGiven    = 0;
        prevReq     = 1'b0;
        nDown       = 0;
        nDone       = 0;
        nDeny       = 0;
        nFault      = 0;
        nReqRise    = 0;
        nReqCycles  = 0;
        doneCyc     = -1;
        denyCyc     = -1;
        faultCyc    = -1;
        lastRiseCyc = -1;
        timedOut    = 0;
        wd_en       = 1'b0;
        disp_ack    = 1'b0;
        @(posedge clk); #1;
        amount  = 8'(amt);
        balance = 16'(bal);
        wd_en   = 1'b1;
        cyc     = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (count_down) nDown++;
            if (done) begin nDone++; doneCyc = cyc; end
            if (deny) begin nDeny++; denyCyc = cyc; end
            if (fault) begin nFault++; faultCyc = cyc; end
            if (disp_req) nReqCycles++;
            if (disp_req && !prevReq) begin nReqRise++; lastRiseCyc = cyc; end
            if (done || deny || fault || !busy) begin
                wd_en = 1'b0;
            end else if (strayMode != 0) begin
                wd_en = ((cyc % 3) == 0);
            end else begin
                wd_en = 1'b0;
            end
            if (disp_req) begin
                disp_ack = prevReq && (ackGiven < ackNotes);
                if (disp_ack) ackGiven++;
            end else begin
                disp_ack = (strayMode != 0) && ((cyc % 2) == 0) && busy;
            end
            prevReq = disp_req;
            if (!busy) break;
            if (cyc >= maxCycles) begin
                timedOut = 1;
                break;
            end
        end
        wd_en    = 1'b0;
        disp_ack = 1'b0;
    endtask

    task automatic pulseDayClr();
        day_clr = 1'b1;
        @(posedge clk); #1;
        day_clr = 1'b0;
    endtask

    // Directed sequence
    initial begin
        checks   = 0;
        failures = 0;
        res      = 1'b0;
        wd_en    = 1'b1;
        amount   = 8'd0;
        balance  = 16'd0;
        disp_ack = 1'b0;
        day_clr  = 1'b0;

        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_disp_req", disp_req, 0);
        checkOutput("reset_pulses", {count_down, done, deny, fault}, 0);

        @(posedge clk); @(posedge clk); #1;
        res = 1'b1;
        sawBusy = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (busy) sawBusy = 1;
        end
        checkOutput("held_wd_en_no_start", sawBusy, 0);

        $display("[TB] three-note withdrawal");
        applyStimulus(3, 10, 3, 0, 60);
        checkOutput("ok3_timeout", timedOut, 0);
        checkOutput("ok3_count_down", nDown, 3);
        checkOutput("ok3_done", nDone, 1);
        checkOutput("ok3_done_cycle", doneCyc, 11);
        checkOutput("ok3_deny", nDeny, 0);
        checkOutput("ok3_fault", nFault, 0);
        checkOutput("ok3_req_rises", nReqRise, 3);

        $display("[TB] deny: amount above balance");
        applyStimulus(5, 2, 5, 0, 20);
        checkOutput("deny_bal_cycle", denyCyc, 2);
        checkOutput("deny_bal_count", nDeny, 1);
        checkOutput("deny_bal_req", nReqCycles, 0);
        checkOutput("deny_bal_down", nDown, 0);

        $display("[TB] deny: zero amount");
        applyStimulus(0, 100, 0, 0, 20);
        checkOutput("deny_zero_cycle", denyCyc, 2);
        checkOutput("deny_zero_req", nReqCycles, 0);
        checkOutput("deny_zero_down", nDown, 0);

        $display("[TB] deny: above per-transaction limit");
        applyStimulus(41, 100, 41, 0, 20);
        checkOutput("deny_max_cycle", denyCyc, 2);
        checkOutput("deny_max_req", nReqCycles, 0);
        checkOutput("deny_max_down", nDown, 0);

        $display("[TB] exactly at per-transaction limit");
        applyStimulus(40, 40, 40, 0, 200);
        checkOutput("max40_down", nDown, 40);
        checkOutput("max40_done_cycle", doneCyc, 122);

        $display("[TB] dispenser timeout on second note");
        applyStimulus(2, 10, 1, 0, 1100);
        checkOutput("fault_timeout", timedOut, 0);
        checkOutput("fault_down", nDown, 1);
        checkOutput("fault_count", nFault, 1);
        checkOutput("fault_done", nDone, 0);
        checkOutput("fault_second_rise", lastRiseCyc, 5);
        checkOutput("fault_cycle", faultCyc, 1005);
        @(posedge clk); #1;
        checkOutput("fault_busy_after", busy, 0);

        $display("[TB] stray ack and wd_en edges during four-note withdrawal");
        applyStimulus(4, 50, 4, 1, 80);
        checkOutput("stray_down", nDown, 4);
        checkOutput("stray_done", nDone, 1);
        checkOutput("stray_done_cycle", doneCyc, 14);
        sawBusy = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy) sawBusy = 1;
        end
        checkOutput("stray_no_restart", sawBusy, 0);

`ifdef WD_DAILY_LIMIT_EN
        $display("[TB] daily limit enabled");
        pulseDayClr();
        applyStimulus(4, 100, 4, 0, 60);
        checkOutput("daily_first_done", nDone, 1);
        applyStimulus(2, 100, 2, 0, 60);
        checkOutput("daily_over_deny", nDeny, 1);
        checkOutput("daily_over_down", nDown, 0);
        pulseDayClr();
        applyStimulus(2, 100, 2, 0, 60);
        checkOutput("daily_clr_done", nDone, 1);
        checkOutput("daily_clr_down", nDown, 2);
`else
        $display("[TB] daily limit disabled");
        pulseDayClr();
        applyStimulus(4, 100, 4, 0, 60);
        checkOutput("nodaily_first_done", nDone, 1);
        applyStimulus(2, 100, 2, 0, 60);
        checkOutput("nodaily_second_deny", nDeny, 0);
        checkOutput("nodaily_second_down", nDown, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
